// File: rtl/dvp_conf_initiator_if.sv
// AXI4 control-path bundle between the DVP config initiator
// and the config register slave (AW/W/B and AR/R channels).
interface dvp_conf_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 5
);
  logic [ID_W-1:0]   m_awid_o;
  logic [ADDR_W-1:0] m_awaddr_o;
  logic              m_awvalid_o;
  logic              m_awready_i;
  logic [DATA_W-1:0] m_wdata_o;
  logic              m_wvalid_o;
  logic              m_wready_i;
  logic [1:0]        m_bresp_i;
  logic              m_bvalid_i;
  logic              m_bready_o;
  logic [ID_W-1:0]   m_arid_o;
  logic [ADDR_W-1:0] m_araddr_o;
  logic              m_arvalid_o;
  logic              m_arready_i;
  logic [DATA_W-1:0] m_rdata_i;
  logic [1:0]        m_rresp_i;
  logic              m_rvalid_i;
  logic              m_rready_o;

  modport master (
    output m_awid_o, m_awaddr_o, m_awvalid_o,
    input  m_awready_i,
    output m_wdata_o, m_wvalid_o,
    input  m_wready_i,
    input  m_bresp_i, m_bvalid_i,
    output m_bready_o,
    output m_arid_o, m_araddr_o, m_arvalid_o,
    input  m_arready_i,
    input  m_rdata_i, m_rresp_i, m_rvalid_i,
    output m_rready_o
  );

  modport slave (
    input  m_awid_o, m_awaddr_o, m_awvalid_o,
    output m_awready_i,
    input  m_wdata_o, m_wvalid_o,
    output m_wready_i,
    output m_bresp_i, m_bvalid_i,
    input  m_bready_o,
    input  m_arid_o, m_araddr_o, m_arvalid_o,
    output m_arready_i,
    output m_rdata_i, m_rresp_i, m_rvalid_i,
    input  m_rready_o
  );
endinterface

// File: rtl/dvp_conf_initiator.sv
// Single-outstanding AXI4 initiator turning a simple cmd/rsp
// port into AW/W/B and AR/R transactions for the DVP config regs.
module dvp_conf_initiator #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MST_ID_W = 5,
  parameter logic [MST_ID_W-1:0] MST_ID = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  dvp_conf_initiator_if.master m
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP
  } state_t;

  state_t r_state, w_next;

  logic              r_cmd_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_awvalid, r_wvalid, r_bready;
  logic              r_arvalid, r_rready;
  logic              r_aw_done, r_w_done;
  logic              r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_data;

  logic w_acc, w_aw_hs, w_w_hs, w_b_hs;
  logic w_ar_hs, w_r_hs, w_aw_ok, w_w_ok;

  assign w_acc   = cmd_valid_i & r_cmd_ready &
                   (r_state == IDLE);
  assign w_aw_hs = r_awvalid & m.m_awready_i;
  assign w_w_hs  = r_wvalid & m.m_wready_i;
  assign w_b_hs  = r_bready & m.m_bvalid_i;
  assign w_ar_hs = r_arvalid & m.m_arready_i;
  assign w_r_hs  = r_rready & m.m_rvalid_i;
  // AW and W complete independently; either may land first
  assign w_aw_ok = r_aw_done | w_aw_hs;
  assign w_w_ok  = r_w_done | w_w_hs;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:
        if (w_acc)
          w_next = cmd_wr_i ? WR_REQ : RD_REQ;
      WR_REQ:
        if (w_aw_ok && w_w_ok) w_next = WR_RESP;
      WR_RESP:
        if (w_b_hs) w_next = IDLE;
      RD_REQ:
        if (w_ar_hs) w_next = RD_RESP;
      RD_RESP:
        if (w_r_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_cmd_ready <= (w_next == IDLE);
      if (w_acc) begin
        r_addr    <= cmd_addr_i;
        r_wdata   <= cmd_wdata_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        if (cmd_wr_i) begin
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
        end else begin
          r_arvalid <= 1'b1;
        end
      end
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (r_state == WR_REQ && w_next == WR_RESP)
        r_bready <= 1'b1;
      if (w_b_hs) begin
        r_bready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= |m.m_bresp_i;
        r_rsp_data  <= '0;
      end
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (w_r_hs) begin
        r_rready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= |m.m_rresp_i;
        r_rsp_data  <= m.m_rdata_i;
      end
    end
  end

  assign cmd_ready_o   = r_cmd_ready;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_data_o    = r_rsp_data;
  assign rsp_err_o     = r_rsp_err;
  assign m.m_awid_o    = MST_ID;
  assign m.m_awaddr_o  = r_addr;
  assign m.m_awvalid_o = r_awvalid;
  assign m.m_wdata_o   = r_wdata;
  assign m.m_wvalid_o  = r_wvalid;
  assign m.m_bready_o  = r_bready;
  assign m.m_arid_o    = MST_ID;
  assign m.m_araddr_o  = r_addr;
  assign m.m_arvalid_o = r_arvalid;
  assign m.m_rready_o  = r_rready;

endmodule
